// File: rtl/alu.sv
// alu: 16-bit ALU with register forms and 8-bit immediate forms; C and Flags are registered.
// Latency: 1 cycle. C and Flags load on every rising clk edge from the inputs present at that edge.
// Backpressure: none. A new operation is accepted every cycle and never stalls.
//
// Ports:
//   clk     rising-edge clock
//   reset   asynchronous active-high reset; clears C and Flags
//   A       first operand (destination register value)
//   B       second operand; immediate forms use only B[7:0]
//   Opcode  operation select
//   C       registered result
//   Flags   registered flags {carry/borrow, low, overflow, zero, negative}
//
// Optional feature: define ALU_SHIFT_EN to enable LSH (0x84) and LSHI (0x80/0x81).
module alu (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic [7:0]  Opcode,
  output logic [15:0] C,
  output logic [4:0]  Flags
);

  typedef enum logic [3:0] {
    OP_NONE,
    OP_AND,
    OP_OR,
    OP_XOR,
    OP_ADD,
    OP_SUB,
    OP_CMP,
    OP_SHL,
    OP_SHR
  } op_e;

  op_e         op;
  logic        imm;

  logic [15:0] b_sx;
  logic [15:0] b_zx;
  logic [15:0] b_arith;
  logic [15:0] b_logic;
  logic [16:0] sum;
  logic [15:0] diff;

  logic [15:0] res;
  logic        cf;
  logic        lf;
  logic        ff;
  logic        zf;
  logic        nf;
  logic        upd;

  // Opcode decode. Register forms live in the 0x0_ row and need all 8 bits.
  // Immediate forms key on the high nibble only; the low nibble is a don't-care.
  always_comb begin
    op  = OP_NONE;
    imm = 1'b0;
    case (Opcode[7:4])
      4'h0: begin
        case (Opcode[3:0])
          4'h1:    op = OP_AND;
          4'h2:    op = OP_OR;
          4'h3:    op = OP_XOR;
          4'h5:    op = OP_ADD;
          4'h9:    op = OP_SUB;
          4'hB:    op = OP_CMP;
          default: op = OP_NONE;
        endcase
      end
      4'h1: begin op = OP_AND; imm = 1'b1; end
      4'h2: begin op = OP_OR;  imm = 1'b1; end
      4'h3: begin op = OP_XOR; imm = 1'b1; end
      4'h5: begin op = OP_ADD; imm = 1'b1; end
      4'h9: begin op = OP_SUB; imm = 1'b1; end
      4'hB: begin op = OP_CMP; imm = 1'b1; end
`ifdef ALU_SHIFT_EN
      4'h8: begin
        case (Opcode[3:0])
          4'h0:    op = OP_SHL;
          4'h1:    op = OP_SHR;
          4'h4:    op = B[4] ? OP_SHR : OP_SHL;
          default: op = OP_NONE;
        endcase
      end
`endif
      default: op = OP_NONE;
    endcase
  end

  // Arithmetic immediates are signed; logic immediates are unsigned.
  // Unsigned comparisons (borrow, low) read an immediate as its 0..255 value,
  // while the arithmetic result and signed checks use the sign-extended form.
  assign b_sx    = {{8{B[7]}}, B[7:0]};
  assign b_zx    = {8'h00, B[7:0]};
  assign b_arith = imm ? b_sx : B;
  assign b_logic = imm ? b_zx : B;
  assign sum     = {1'b0, A} + {1'b0, b_arith};
  assign diff    = A - b_arith;

  always_comb begin
    res = 16'h0000;
    cf  = 1'b0;
    lf  = 1'b0;
    ff  = 1'b0;
    zf  = 1'b0;
    nf  = 1'b0;
    upd = 1'b1;
    case (op)
      OP_AND: res = A & b_logic;
      OP_OR:  res = A | b_logic;
      OP_XOR: res = A ^ b_logic;
      OP_ADD: begin
        res = sum[15:0];
        cf  = sum[16];
        ff  = (A[15] == b_arith[15]) && (sum[15] != A[15]);
      end
      OP_SUB: begin
        res = diff;
        cf  = (A < b_logic);
        ff  = (A[15] != b_arith[15]) && (diff[15] != A[15]);
      end
      OP_CMP: begin
        res = 16'h0000;
        lf  = (A < b_logic);
        nf  = ($signed(A) < $signed(b_arith));
        zf  = (A == b_arith);
      end
      OP_SHL: res = A << B[3:0];
      OP_SHR: res = A >> B[3:0];
      // Unsupported opcode: C goes to zero, Flags keep their last value.
      default: upd = 1'b0;
    endcase
    if (op != OP_CMP) begin
      zf = (res == 16'h0000);
      nf = res[15];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      C     <= 16'h0000;
      Flags <= 5'b00000;
    end else begin
      C <= res;
      if (upd) begin
        Flags <= {cf, lf, ff, zf, nf};
      end
    end
  end

endmodule

// File: tb/tb_alu.sv
module tb_alu;

  logic        clk;
  logic        reset;
  logic [15:0] a;
  logic [15:0] b;
  logic [7:0]  op;
  logic [15:0] c;
  logic [4:0]  flags;

  int checks   = 0;
  int failures = 0;

  // Scoreboard entries are {C, Flags}.
  logic [20:0] sbq[$];
  logic [4:0]  mflags;

  alu dut (
    .clk    (clk),
    .reset  (reset),
    .A      (a),
    .B      (b),
    .Opcode (op),
    .C      (c),
    .Flags  (flags)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // Reference model, written from the operation definitions using integer arithmetic.
  function automatic logic [20:0] model(input logic [7:0] o, input logic [15:0] x,
                                        input logic [15:0] y, input logic [4:0] pf);
    logic        im;
    logic [3:0]  k;
    logic [15:0] yz;
    logic [15:0] ys;
    logic [15:0] r;
    logic        cf, lf, ff, zf, nf;
    int          s;
    int          sx;
    int          sy;
    if (o[7:4] == 4'h0) begin
      k  = o[3:0];
      im = 1'b0;
    end else begin
      k  = o[7:4];
      im = 1'b1;
    end
    if (!(k inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB}))
      return {16'h0000, pf};
    yz = im ? {8'h00, y[7:0]} : y;
    ys = im ? {{8{y[7]}}, y[7:0]} : y;
    sx = int'($signed(x));
    sy = int'($signed(ys));
    r  = 16'h0000;
    s  = 0;
    cf = 0; lf = 0; ff = 0; zf = 0; nf = 0;
    case (k)
      4'h1: r = x & yz;
      4'h2: r = x | yz;
      4'h3: r = x ^ yz;
      4'h5: begin
        s  = int'(x) + int'(ys);
        r  = s[15:0];
        cf = (s > 65535);
        ff = ((sx + sy) > 32767) || ((sx + sy) < -32768);
      end
      4'h9: begin
        s  = int'(x) - int'(ys);
        r  = s[15:0];
        cf = (int'(x) < int'(yz));
        ff = ((sx - sy) > 32767) || ((sx - sy) < -32768);
      end
      default: begin
        r  = 16'h0000;
        lf = (int'(x) < int'(yz));
        nf = (sx < sy);
        zf = (x == ys);
      end
    endcase
    if (k != 4'hB) begin
      zf = (r == 16'h0000);
      nf = r[15];
    end
    return {r, cf, lf, ff, zf, nf};
  endfunction

  // Drive one operation at the falling edge and record what it must produce.
  task automatic put(input logic [7:0] o, input logic [15:0] x, input logic [15:0] y,
                     input logic [20:0] e);
    @(negedge clk);
    op = o;
    a  = x;
    b  = y;
    sbq.push_back(e);
    mflags = e[4:0];
  endtask

  task automatic test_reset;
    reset = 1'b1;
    op    = 8'h05;
    a     = 16'hFFFF;
    b     = 16'h0001;
    sbq.delete();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({c, flags} !== 21'h0) begin
        failures++;
        $display("FAIL reset_hold[%0d] got C=%h Flags=%b required C=0000 Flags=00000", i, c, flags);
      end
    end
    @(negedge clk);
    reset  = 1'b0;
    mflags = 5'b00000;
  endtask

  task automatic test_arith;
    logic [7:0]  ov[9] = '{8'h05, 8'h53, 8'h05, 8'h09, 8'h90, 8'h9F, 8'hB5, 8'h0B, 8'h0B};
    logic [15:0] xv[9] = '{16'h7FFF, 16'h8000, 16'hFFFF, 16'h0000, 16'h7FFF, 16'h8000, 16'h000A, 16'hFFFF, 16'h1234};
    logic [15:0] yv[9] = '{16'h0001, 16'h00FF, 16'h0001, 16'h0001, 16'h00FF, 16'h0001, 16'h0014, 16'h0001, 16'h1234};
    logic [15:0] cv[9] = '{16'h8000, 16'h7FFF, 16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h0000, 16'h0000, 16'h0000};
    logic [4:0]  fv[9] = '{5'b00101, 5'b10100, 5'b10010, 5'b10001, 5'b00101, 5'b00100, 5'b01001, 5'b00001, 5'b00010};
    logic [20:0] got;
    for (int i = 0; i < 9; i++) begin
      put(ov[i], xv[i], yv[i], {cv[i], fv[i]});
      @(posedge clk);
      #1;
      got = sbq.pop_front();
      checks++;
      if ({c, flags} !== got) begin
        failures++;
        $display("FAIL arith[%0d] op=%h got C=%h Flags=%b required C=%h Flags=%b",
                 i, ov[i], c, flags, got[20:5], got[4:0]);
      end
    end
  endtask

  task automatic test_logic;
    logic [7:0]  ov[7] = '{8'b0011xxxx, 8'h1F, 8'h27, 8'h02, 8'h01, 8'h03, 8'h20};
    logic [15:0] xv[7] = '{16'h00F0, 16'hFFFF, 16'h8000, 16'h0F00, 16'hFF00, 16'hAAAA, 16'h0000};
    logic [15:0] yv[7] = '{16'hFF0F, 16'h8000, 16'h00AA, 16'h00F0, 16'h8F0F, 16'hAAAA, 16'hFF80};
    logic [15:0] cv[7] = '{16'h00FF, 16'h0000, 16'h80AA, 16'h0FF0, 16'h8F00, 16'h0000, 16'h0080};
    logic [4:0]  fv[7] = '{5'b00000, 5'b00010, 5'b00001, 5'b00000, 5'b00001, 5'b00010, 5'b00000};
    logic [20:0] got;
    for (int i = 0; i < 7; i++) begin
      put(ov[i], xv[i], yv[i], {cv[i], fv[i]});
      @(posedge clk);
      #1;
      got = sbq.pop_front();
      checks++;
      if ({c, flags} !== got) begin
        failures++;
        $display("FAIL logic[%0d] got C=%h Flags=%b required C=%h Flags=%b",
                 i, c, flags, got[20:5], got[4:0]);
      end
    end
  endtask

  task automatic test_unsupported;
    logic [7:0]  ov[4] = '{8'h05, 8'hFF, 8'h04, 8'h00};
    logic [15:0] xv[4] = '{16'hFFFF, 16'h1234, 16'h8000, 16'h7FFF};
    logic [15:0] yv[4] = '{16'h0001, 16'h5678, 16'h0001, 16'h7FFF};
    logic [20:0] got;
    for (int i = 0; i < 4; i++) begin
      put(ov[i], xv[i], yv[i], {16'h0000, 5'b10010});
      @(posedge clk);
      #1;
      got = sbq.pop_front();
      checks++;
      if ({c, flags} !== got) begin
        failures++;
        $display("FAIL unsupported[%0d] op=%h got C=%h Flags=%b required C=%h Flags=%b",
                 i, ov[i], c, flags, got[20:5], got[4:0]);
      end
    end
  endtask

`ifdef ALU_SHIFT_EN
  task automatic test_shift;
    logic [7:0]  ov[5] = '{8'h80, 8'h81, 8'h84, 8'h84, 8'h84};
    logic [15:0] xv[5] = '{16'h0001, 16'h8000, 16'h00F0, 16'h0001, 16'h8000};
    logic [15:0] yv[5] = '{16'h000F, 16'h000F, 16'h0014, 16'h0010, 16'h0001};
    logic [15:0] cv[5] = '{16'h8000, 16'h0001, 16'h000F, 16'h0001, 16'h0000};
    logic [4:0]  fv[5] = '{5'b00001, 5'b00000, 5'b00000, 5'b00000, 5'b00010};
    logic [20:0] got;
    for (int i = 0; i < 5; i++) begin
      put(ov[i], xv[i], yv[i], {cv[i], fv[i]});
      @(posedge clk);
      #1;
      got = sbq.pop_front();
      checks++;
      if ({c, flags} !== got) begin
        failures++;
        $display("FAIL shift[%0d] got C=%h Flags=%b required C=%h Flags=%b",
                 i, c, flags, got[20:5], got[4:0]);
      end
    end
  endtask
`else
  task automatic test_shift;
    logic [7:0]  ov[4] = '{8'h05, 8'h80, 8'h81, 8'h84};
    logic [15:0] cv[4] = '{16'h8000, 16'h0000, 16'h0000, 16'h0000};
    logic [20:0] got;
    for (int i = 0; i < 4; i++) begin
      put(ov[i], 16'h7FFF, 16'h0001, {cv[i], 5'b00101});
      @(posedge clk);
      #1;
      got = sbq.pop_front();
      checks++;
      if ({c, flags} !== got) begin
        failures++;
        $display("FAIL shift_disabled[%0d] op=%h got C=%h Flags=%b required C=%h Flags=%b",
                 i, ov[i], c, flags, got[20:5], got[4:0]);
      end
    end
  endtask
`endif

  task automatic test_async_reset;
    logic [20:0] got;
    put(8'h05, 16'hFFFF, 16'h0001, {16'h0000, 5'b10010});
    @(posedge clk);
    #1;
    got = sbq.pop_front();
    checks++;
    if ({c, flags} !== got) begin
      failures++;
      $display("FAIL async_pre got C=%h Flags=%b required C=%h Flags=%b", c, flags, got[20:5], got[4:0]);
    end
    put(8'h05, 16'h7FFF, 16'h0001, {16'h8000, 5'b00101});
    @(posedge clk);
    #1;
    got = sbq.pop_front();
    checks++;
    if ({c, flags} !== got) begin
      failures++;
      $display("FAIL async_pre2 got C=%h Flags=%b required C=%h Flags=%b", c, flags, got[20:5], got[4:0]);
    end
    // Assert reset between edges; outputs must clear without a clock edge.
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({c, flags} !== 21'h0) begin
      failures++;
      $display("FAIL async_clear got C=%h Flags=%b required C=0000 Flags=00000", c, flags);
    end
    sbq.delete();
    mflags = 5'b00000;
    // Held across an edge with live inputs, the result stays discarded.
    @(negedge clk);
    op = 8'h05;
    a  = 16'hFFFF;
    b  = 16'h0001;
    @(posedge clk);
    #1;
    checks++;
    if ({c, flags} !== 21'h0) begin
      failures++;
      $display("FAIL async_hold got C=%h Flags=%b required C=0000 Flags=00000", c, flags);
    end
    // First edge after release registers the inputs present then.
    @(negedge clk);
    reset = 1'b0;
    op    = 8'h09;
    a     = 16'h0000;
    b     = 16'h0001;
    sbq.push_back({16'hFFFF, 5'b10001});
    mflags = 5'b10001;
    @(posedge clk);
    #1;
    got = sbq.pop_front();
    checks++;
    if ({c, flags} !== got) begin
      failures++;
      $display("FAIL async_release got C=%h Flags=%b required C=%h Flags=%b", c, flags, got[20:5], got[4:0]);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0]  ops[19] = '{8'h01, 8'h02, 8'h03, 8'h05, 8'h09, 8'h0B,
                             8'h10, 8'h20, 8'h30, 8'h50, 8'h90, 8'hB0,
                             8'h00, 8'h04, 8'h0F, 8'h40, 8'h6A, 8'hFF, 8'hC3};
    logic [7:0]  o;
    logic [15:0] x;
    logic [15:0] y;
    logic [20:0] got;
    int          idx;
    for (int i = 0; i < 80; i++) begin
      idx = $urandom_range(0, 18);
      o   = ops[idx];
      if (idx >= 6 && idx <= 11) o[3:0] = 4'($urandom_range(0, 15));
      x = 16'($urandom_range(0, 65535));
      y = 16'($urandom_range(0, 65535));
      if (i % 8 == 0) x = 16'h7FFF;
      if (i % 8 == 1) x = 16'h8000;
      if (i % 8 == 2) y = x;
      put(o, x, y, model(o, x, y, mflags));
      @(posedge clk);
      #1;
      got = sbq.pop_front();
      checks++;
      if ({c, flags} !== got) begin
        failures++;
        $display("FAIL random[%0d] op=%h a=%h b=%h got C=%h Flags=%b required C=%h Flags=%b",
                 i, o, x, y, c, flags, got[20:5], got[4:0]);
      end
    end
  endtask

  initial begin
    reset  = 1'b1;
    op     = 8'h00;
    a      = 16'h0000;
    b      = 16'h0000;
    mflags = 5'b00000;
    test_reset();
    test_arith();
    test_logic();
    test_unsupported();
    test_shift();
    test_async_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
